wb_select_stage: RTL and testbench
==================================

// Module: wb_select_stage
// PURPOSE
//  MEM/WB pipeline register fused with a parametrised N-source writeback-data selector.
//  Load-data extension (byte/half, signed/unsigned) is applied before the data is registered.
//  Drives the GRF write port and the WB-stage forwarding bus.
//  Supersedes the fixed 3-input combinational writeback mux; adds stall, flush, valid tracking and a retire counter.
// PARAMETERS
//  DW      32   datapath width, >= 32
//  NSRC    4    number of writeback data sources, 2..8
//  SELW    3    source-select width; must satisfy 2**SELW >= NSRC
//  AW      5    register-address width
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-low reset
//  m_valid      in   1          MEM stage holds a real instruction
//  m_src_data   in   NSRC*DW    packed sources; source i = [i*DW +: DW]
//  m_src_sel    in   SELW       index of the writeback source
//  m_ld_ext     in   3          load-extension mode (package encoding)
//  m_addr_lo    in   2          data-address bits [1:0], used for byte/half lane select
//  m_we         in   1          instruction writes the GRF
//  m_wa         in   AW         destination register
//  stall        in   1          hold the WB register contents
//  flush        in   1          insert a bubble into WB
//  wb_valid     out  1          WB holds a real instruction
//  wb_we        out  1          GRF write enable
//  wb_wa        out  AW         GRF write address
//  wb_wd        out  DW         GRF write data; also the forwarding value
//  sel_err      out  1          sticky: an out-of-range select was captured
//  retire_cnt   out  32         count of valid instructions leaving WB
// BEHAVIOUR
//  - Reset (reset==0, async): wb_valid, wb_we, wb_wa, wb_wd, sel_err and retire_cnt clear to 0 immediately, mid-operation included.
//  - Latency: 1 cycle. Inputs sampled at posedge clk appear on wb_* after that edge.
//  - Capture priority per posedge: flush > stall > load.
//  - flush=1 (stall ignored): wb_valid=0, wb_we=0, wb_wa=0, wb_wd=0.
//  - stall=1, flush=0: all wb_* hold their values. The retire counter does not increment.
//  - load (flush=0, stall=0):
//    - wb_valid = m_valid.
//    - wb_we = m_valid & m_we & (m_wa != 0). A write to $0 is never issued.
//    - wb_wa = m_wa.
//    - wb_wd = ext(m_src_data[m_src_sel]).
//  - Out-of-range select (m_src_sel >= NSRC) on a load with m_valid=1:
//    - wb_wd = 0 and wb_we = 0.
//    - sel_err sets and stays set until reset.
//  - Extension applies only when m_src_sel == SRC_MEM; all other sources pass through unmodified.
//    - LX_W: the full word passes through.
//    - LX_B / LX_BU: byte m_addr_lo, sign- or zero-extended.
//    - LX_H / LX_HU: half m_addr_lo[1], sign- or zero-extended; m_addr_lo[0] is ignored.
//    - Encodings 5..7: treated as LX_W.
//  - retire_cnt increments by 1 on every posedge where wb_valid==1 and (stall==0 or flush==1).
//    - It wraps 0xFFFFFFFF -> 0.
//    - A flush that displaces a valid WB instruction still counts that instruction as retired.
//  - Outputs are registers only; there is no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package cpu_defs_pkg holds:
//    - load-extension codes LX_W=0, LX_B=1, LX_BU=2, LX_H=3, LX_HU=4;
//    - source indices SRC_ALU=0, SRC_MEM=1, SRC_PC8=2, SRC_HILO=3.
//  - Sub-module wb_load_ext: combinational lane select and extension.
//    - Inputs: word, mode, addr_lo. Output: DW-wide result.
//    - Instantiated once, ahead of the WB register.
//  - Selection uses an indexed part-select on m_src_data; no per-width case lists.
// TESTING
//  1. Reset then one load: reset low for 3 cycles, then high; m_valid=1, sel=SRC_ALU, src0=0x12345678, we=1, wa=8 -> after one edge wb_wd=0x12345678, wb_we=1, wb_wa=8, wb_valid=1.
//  2. Byte load: sel=SRC_MEM, src1=0x80FF7F01, LX_B, addr_lo=3 -> wb_wd=0xFFFFFF80; same inputs with LX_BU -> 0x00000080; LX_H, addr_lo=2 -> 0xFFFF80FF.
//  3. $0 guard plus bad select: wa=0, we=1 -> wb_we=0. With NSRC=3, sel=3 -> wb_wd=0, wb_we=0, sel_err=1, and sel_err stays 1 over 10 later clean cycles.
//  4. Stall/flush ordering: stall=1 for 4 cycles -> wb_* frozen and retire_cnt constant; stall=1 and flush=1 together -> bubble loaded, retire_cnt +1.
//  5. Counter wrap: preload via 2^32-1 retirements (or force) -> next valid retire gives retire_cnt=0.
//  6. Async reset mid-stream: drop reset between edges while wb_valid=1 -> all outputs 0 before the next posedge.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU encodings: load-extension modes and writeback-source indices.
package cpu_defs_pkg;

   typedef enum logic [2:0] {
      LX_W  = 3'd0,
      LX_B  = 3'd1,
      LX_BU = 3'd2,
      LX_H  = 3'd3,
      LX_HU = 3'd4
   } lx_mode_e;

   localparam int SRC_ALU  = 0;
   localparam int SRC_MEM  = 1;
   localparam int SRC_PC8  = 2;
   localparam int SRC_HILO = 3;

endpackage

// File: rtl/wb_load_ext.sv
// Load-data lane select and sign/zero extension for byte and half loads.
module wb_load_ext
   import cpu_defs_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] word,
   input  logic [2:0]    mode,
   input  logic [1:0]    addr_lo,
   output logic [DW-1:0] result
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed lane, then extend it according to the mode.
   always_comb begin
      byte_s = word[{addr_lo, 3'b000} +: 8];
      half_s = word[{addr_lo[1], 4'b0000} +: 16];
      case (mode)
         LX_B:    result = {{(DW-8){byte_s[7]}}, byte_s};
         LX_BU:   result = {{(DW-8){1'b0}}, byte_s};
         LX_H:    result = {{(DW-16){half_s[15]}}, half_s};
         LX_HU:   result = {{(DW-16){1'b0}}, half_s};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB pipeline register with N-source writeback selection, load extension,
// stall/flush handling, a sticky bad-select flag and a retire counter.
module wb_select_stage
   import cpu_defs_pkg::*;
#(
   parameter int DW   = 32,
   parameter int NSRC = 4,
   parameter int SELW = 3,
   parameter int AW   = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               m_valid,
   input  logic [NSRC*DW-1:0] m_src_data,
   input  logic [SELW-1:0]    m_src_sel,
   input  logic [2:0]         m_ld_ext,
   input  logic [1:0]         m_addr_lo,
   input  logic               m_we,
   input  logic [AW-1:0]      m_wa,
   input  logic               stall,
   input  logic               flush,
   output logic               wb_valid,
   output logic               wb_we,
   output logic [AW-1:0]      wb_wa,
   output logic [DW-1:0]      wb_wd,
   output logic               sel_err,
   output logic [31:0]        retire_cnt
);

   logic          sel_ok_s;
   logic          is_mem_s;
   logic          load_s;
   logic [DW-1:0] raw_s;
   logic [DW-1:0] ext_s;
   logic [DW-1:0] wd_next_s;
   logic          we_next_s;

   logic          wb_valid_r;
   logic          wb_we_r;
   logic [AW-1:0] wb_wa_r;
   logic [DW-1:0] wb_wd_r;
   logic          sel_err_r;
   logic [31:0]   retire_cnt_r;

   wb_load_ext #(.DW(DW)) u_ext (
      .word    (raw_s),
      .mode    (m_ld_ext),
      .addr_lo (m_addr_lo),
      .result  (ext_s)
   );

   // Source selection and next-state values for the WB register.
   always_comb begin
      sel_ok_s = ({{(32-SELW){1'b0}}, m_src_sel} < NSRC);
      is_mem_s = (m_src_sel == SELW'(SRC_MEM));
      load_s   = !flush && !stall;
      if (sel_ok_s) begin
         raw_s = m_src_data[m_src_sel*DW +: DW];
      end else begin
         raw_s = {DW{1'b0}};
      end
      if (!sel_ok_s) begin
         wd_next_s = {DW{1'b0}};
      end else if (is_mem_s) begin
         wd_next_s = ext_s;
      end else begin
         wd_next_s = raw_s;
      end
      we_next_s = m_valid && m_we && (m_wa != {AW{1'b0}}) && sel_ok_s;
   end

   // WB register, sticky select error and retire counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid_r   <= 1'b0;
         wb_we_r      <= 1'b0;
         wb_wa_r      <= {AW{1'b0}};
         wb_wd_r      <= {DW{1'b0}};
         sel_err_r    <= 1'b0;
         retire_cnt_r <= 32'd0;
      end else begin
         if (flush) begin
            wb_valid_r <= 1'b0;
            wb_we_r    <= 1'b0;
            wb_wa_r    <= {AW{1'b0}};
            wb_wd_r    <= {DW{1'b0}};
         end else if (!stall) begin
            wb_valid_r <= m_valid;
            wb_we_r    <= we_next_s;
            wb_wa_r    <= m_wa;
            wb_wd_r    <= wd_next_s;
         end
         // A flushed-out valid instruction has still completed, so it counts.
         if (wb_valid_r && (!stall || flush)) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
         end
         if (load_s && m_valid && !sel_ok_s) begin
            sel_err_r <= 1'b1;
         end
      end
   end

   assign wb_valid   = wb_valid_r;
   assign wb_we      = wb_we_r;
   assign wb_wa      = wb_wa_r;
   assign wb_wd      = wb_wd_r;
   assign sel_err    = sel_err_r;
   assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage built with three sources so select 3 is out of range.
module tb_wb_select_stage;
   import cpu_defs_pkg::*;

   localparam int DW   = 32;
   localparam int NSRC = 3;
   localparam int SELW = 2;
   localparam int AW   = 5;

   logic               clk;
   logic               reset;
   logic               m_valid;
   logic [NSRC*DW-1:0] m_src_data;
   logic [SELW-1:0]    m_src_sel;
   logic [2:0]         m_ld_ext;
   logic [1:0]         m_addr_lo;
   logic               m_we;
   logic [AW-1:0]      m_wa;
   logic               stall;
   logic               flush;
   logic               wb_valid;
   logic               wb_we;
   logic [AW-1:0]      wb_wa;
   logic [DW-1:0]      wb_wd;
   logic               sel_err;
   logic [31:0]        retire_cnt;

   int n_vec = 0;
   int n_err = 0;

   wb_select_stage #(.DW(DW), .NSRC(NSRC), .SELW(SELW), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .m_valid    (m_valid),
      .m_src_data (m_src_data),
      .m_src_sel  (m_src_sel),
      .m_ld_ext   (m_ld_ext),
      .m_addr_lo  (m_addr_lo),
      .m_we       (m_we),
      .m_wa       (m_wa),
      .stall      (stall),
      .flush      (flush),
      .wb_valid   (wb_valid),
      .wb_we      (wb_we),
      .wb_wa      (wb_wa),
      .wb_wd      (wb_wd),
      .sel_err    (sel_err),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b0;
      m_valid    = 1'b0;
      m_src_data = {32'hA5A5_A5A5, 32'h80FF_7F01, 32'h1234_5678};
      m_src_sel  = 2'd0;
      m_ld_ext   = 3'd0;
      m_addr_lo  = 2'd0;
      m_we       = 1'b0;
      m_wa       = 5'd0;
      stall      = 1'b0;
      flush      = 1'b0;
      repeat (3) tick();
      chk("rst_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_we",    {31'd0, wb_we},    32'd0);
      chk("rst_wa",    {27'd0, wb_wa},    32'd0);
      chk("rst_wd",    wb_wd,             32'd0);
      chk("rst_err",   {31'd0, sel_err},  32'd0);
      chk("rst_cnt",   retire_cnt,        32'd0);
      reset = 1'b1;

      // 1: plain ALU load
      m_valid = 1'b1; m_src_sel = 2'd0; m_ld_ext = LX_W; m_we = 1'b1; m_wa = 5'd8;
      tick();
      chk("alu_wd",    wb_wd,             32'h1234_5678);
      chk("alu_we",    {31'd0, wb_we},    32'd1);
      chk("alu_wa",    {27'd0, wb_wa},    32'd8);
      chk("alu_valid", {31'd0, wb_valid}, 32'd1);
      chk("alu_cnt",   retire_cnt,        32'd0);

      // 2: load extension on the memory source
      m_src_sel = 2'd1; m_ld_ext = LX_B; m_addr_lo = 2'd3;
      tick();
      chk("lb3", wb_wd, 32'hFFFF_FF80);
      chk("cnt1", retire_cnt, 32'd1);
      m_ld_ext = LX_BU;
      tick();
      chk("lbu3", wb_wd, 32'h0000_0080);
      m_ld_ext = LX_H; m_addr_lo = 2'd2;
      tick();
      chk("lh2", wb_wd, 32'hFFFF_80FF);
      m_ld_ext = LX_HU; m_addr_lo = 2'd3;
      tick();
      chk("lhu3", wb_wd, 32'h0000_80FF);
      m_ld_ext = LX_B; m_addr_lo = 2'd0;
      tick();
      chk("lb0", wb_wd, 32'h0000_0001);
      m_src_sel = 2'd2; m_addr_lo = 2'd3;
      tick();
      chk("pc8_noext", wb_wd, 32'hA5A5_A5A5);
      m_src_sel = 2'd1; m_ld_ext = 3'd7;
      tick();
      chk("mode7_word", wb_wd, 32'h80FF_7F01);
      chk("cnt7", retire_cnt, 32'd7);

      // 3: $0 guard and out-of-range select
      m_src_sel = 2'd0; m_ld_ext = LX_W; m_wa = 5'd0;
      tick();
      chk("r0_we",    {31'd0, wb_we},    32'd0);
      chk("r0_valid", {31'd0, wb_valid}, 32'd1);
      m_src_sel = 2'd3; m_wa = 5'd9;
      tick();
      chk("bad_wd",  wb_wd,            32'd0);
      chk("bad_we",  {31'd0, wb_we},   32'd0);
      chk("bad_err", {31'd0, sel_err}, 32'd1);
      m_src_sel = 2'd0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("err_sticky", {31'd0, sel_err}, 32'd1);
      end
      chk("clean_wd",  wb_wd,          32'h1234_5678);
      chk("clean_we",  {31'd0, wb_we}, 32'd1);
      chk("cnt19",     retire_cnt,     32'd19);

      // 4: stall freezes, flush wins over stall
      m_src_sel = 2'd1; m_wa = 5'd3; stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_wd",  wb_wd,          32'h1234_5678);
         chk("stall_wa",  {27'd0, wb_wa}, 32'd9);
         chk("stall_cnt", retire_cnt,     32'd19);
      end
      flush = 1'b1;
      tick();
      chk("flush_valid", {31'd0, wb_valid}, 32'd0);
      chk("flush_we",    {31'd0, wb_we},    32'd0);
      chk("flush_wa",    {27'd0, wb_wa},    32'd0);
      chk("flush_wd",    wb_wd,             32'd0);
      chk("flush_cnt",   retire_cnt,        32'd20);
      stall = 1'b0; flush = 1'b0;
      tick();
      chk("post_flush_wd",  wb_wd,      32'h80FF_7F01);
      chk("post_flush_cnt", retire_cnt, 32'd20);
      m_valid = 1'b0;
      tick();
      chk("inv_valid", {31'd0, wb_valid}, 32'd0);
      chk("inv_we",    {31'd0, wb_we},    32'd0);
      chk("inv_cnt",   retire_cnt,        32'd21);
      flush = 1'b1;
      tick();
      chk("flush_bubble_cnt", retire_cnt, 32'd21);
      flush = 1'b0;

      // 5: counter wrap
      m_valid = 1'b1; m_src_sel = 2'd0; m_wa = 5'd4;
      tick();
      chk("pre_wrap_cnt", retire_cnt, 32'd21);
      force dut.retire_cnt_r = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_r;
      tick();
      chk("wrap_cnt", retire_cnt, 32'd0);

      // 6: asynchronous reset between edges
      chk("pre_rst_valid", {31'd0, wb_valid}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_valid", {31'd0, wb_valid}, 32'd0);
      chk("arst_we",    {31'd0, wb_we},    32'd0);
      chk("arst_wa",    {27'd0, wb_wa},    32'd0);
      chk("arst_wd",    wb_wd,             32'd0);
      chk("arst_err",   {31'd0, sel_err},  32'd0);
      chk("arst_cnt",   retire_cnt,        32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
